// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, the
// line-rate constants and the default frame shape.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

    localparam int CLK_HZ       = 49152000;
    localparam int BAUD         = 9600;
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;     // 5120
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;  // 2560

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_STOP_BITS = 1;

    // Terminal value of a 4-bit sample counter that must see n samples.
    function automatic logic [3:0] last_count(input int n);
        return 4'(n - 1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for the asynchronous serial line, idling high,
// with a single-cycle falling-edge pulse on the synchronised output.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic rxd_s_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // All stages reset to the idle level so reset release never fakes a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rxd_s_o = sync_q[SYNC_STAGES-1];
    assign fall_o  = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame_module.sv
// UART frame receiver driven by an external mid-bit strobe; delivers bytes on a
// valid/ready holding register. Define UART_RX_PARITY_EN to add a parity bit.
module uart_rx_frame_module
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DEFAULT_DATA_BITS,
    parameter int STOP_BITS   = DEFAULT_STOP_BITS,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic                 bps_clk,
    output logic                 bps_sync,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam logic [3:0] LAST_DATA  = last_count(DATA_BITS);
    localparam logic [3:0] LAST_STOP  = last_count(STOP_BITS);
    localparam logic       PAR_SENSE  = (PARITY_ODD != 0);

    logic rxd_s;
    logic rxd_fall;

    rx_state_e            state_q,     state_d;
    logic [3:0]           bitcnt_q,    bitcnt_d;
    logic [3:0]           stopcnt_q,   stopcnt_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic                 bad_q,       bad_d;
    logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic                 rx_valid_q,  rx_valid_d;
    logic                 bps_sync_q,  bps_sync_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q,   overrun_d;

    logic frame_good;
    logic stop_bad;
    logic accept;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .din_i   (rxd),
        .rxd_s_o (rxd_s),
        .fall_o  (rxd_fall)
    );

    assign accept = rx_valid_q & rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            stopcnt_q   <= '0;
            shift_q     <= '0;
            bad_q       <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            bps_sync_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            stopcnt_q   <= stopcnt_d;
            shift_q     <= shift_d;
            bad_q       <= bad_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            bps_sync_q  <= bps_sync_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        stopcnt_d   = stopcnt_q;
        shift_d     = shift_q;
        bad_d       = bad_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        bps_sync_d  = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        frame_good  = 1'b0;
        stop_bad    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rxd_fall) begin
                    bps_sync_d = 1'b1;
                    state_d    = ST_START;
                end
            end

            ST_START: begin
                if (bps_clk) begin
                    if (!rxd_s) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                        bad_d    = 1'b0;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                if (bps_clk) begin
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    if (bitcnt_q == LAST_DATA) begin
                        state_d   = PARITY_EN ? ST_PARITY : ST_STOP;
                        stopcnt_d = '0;
                    end else begin
                        bitcnt_d  = bitcnt_q + 4'd1;
                    end
                end
            end

            ST_PARITY: begin
                if (bps_clk) begin
                    if (rxd_s != ((^shift_q) ^ PAR_SENSE)) begin
                        bad_d = 1'b1;
                    end
                    state_d   = ST_STOP;
                    stopcnt_d = '0;
                end
            end

            ST_STOP: begin
                if (bps_clk) begin
                    stop_bad = bad_q | ~rxd_s;
                    bad_d    = stop_bad;
                    if (stopcnt_q == LAST_STOP) begin
                        if (stop_bad) begin
                            frame_err_d = 1'b1;
                            state_d     = ST_WAIT_IDLE;
                        end else begin
                            frame_good  = 1'b1;
                            state_d     = ST_IDLE;
                        end
                    end else begin
                        stopcnt_d = stopcnt_q + 4'd1;
                    end
                end
            end

            // A held-low line (break) must return high before a new start edge counts.
            ST_WAIT_IDLE: begin
                if (rxd_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A completion in the same cycle as an accept reloads instead of overrunning.
        if (frame_good) begin
            if (!rx_valid_q || accept) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d  = 1'b1;
            end
        end else if (accept) begin
            rx_valid_d = 1'b0;
        end
    end

    assign bps_sync  = bps_sync_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
